uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with an input FIFO and valid/ready handshake, single clock domain.

---
 rtl/uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter fed by an internal word FIFO with a valid/ready write port.
//   The baud timing is a clock-enable counter in the system clock domain, so
//   the whole block runs on clk alone. Frame format is set by parameters:
//   5..8 data bits sent LSB first, optional odd/even parity, 1 or 2 stop bits.
//   Frames queued in the FIFO are sent back to back with no idle gap.
//
// Ports
//   clk         system clock, rising edge
//   reset_p     synchronous active-high reset (aborts any frame in flight)
//   data_i      word to transmit
//   valid_i     data_i is valid; written when valid_i & ready_o at an edge
//   ready_o     FIFO not full (combinational from stored state only)
//   tx          serial line, idle high, driven from a register
//   busy        a frame is on the line or the FIFO holds words
//   fifo_count  number of words currently stored
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int sys_freq   = 100_000_000,
    parameter int BAUD_rate  = 9600,
    parameter int DATA_bits  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_bits  = 1,
    parameter int FIFO_depth = 16
) (
    input  logic                          clk,
    input  logic                          reset_p,
    input  logic [DATA_bits-1:0]          data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_depth):0]   fifo_count
);

    localparam int DIV   = sys_freq / BAUD_rate;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FIFO_depth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO: pointers are one bit wider than the address so that full and
    // empty are distinguishable; the count is simply their difference.
    // ------------------------------------------------------------------
    logic [DATA_bits-1:0] mem [FIFO_depth];
    logic [AW:0]          wr_ptr_reg;
    logic [AW:0]          rd_ptr_reg;
    logic [DATA_bits-1:0] rd_data_reg;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [AW:0]          count_next;

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign full       = (fifo_count == (AW+1)'(FIFO_depth));
    assign empty      = (fifo_count == '0);
    assign ready_o    = !full;
    assign push       = valid_i && ready_o;
    assign count_next = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage array with a registered read port. The popped word lands in
    // rd_data_reg on the pop edge and stays there for the whole frame; it is
    // first needed DIV cycles later when the start bit ends.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (pop) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    // ------------------------------------------------------------------
    // Baud clock-enable: bit_done marks the last cycle of each bit period.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] baud_cnt_reg;
    logic             bit_done;
    state_t           state_reg;
    state_t           state_next;

    assign bit_done = (baud_cnt_reg == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset_p) begin
            baud_cnt_reg <= '0;
        end else if (pop || state_reg == S_IDLE || bit_done) begin
            baud_cnt_reg <= '0;
        end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
        end
    end

    // Parity bit for the frame in rd_data_reg: even parity repeats the XOR
    // of the data, odd parity inverts it.
    logic parity_bit;
    assign parity_bit = (PARITY == 1) ? ~(^rd_data_reg) : (^rd_data_reg);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [DATA_bits-1:0] shift_reg;
    logic [DATA_bits-1:0] shift_next;
    logic [2:0]           bit_cnt_reg;
    logic [2:0]           bit_cnt_next;
    logic                 tx_reg;
    logic                 tx_next;
    logic                 busy_reg;
    logic                 busy_next;

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_START;
                    tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_next   = S_DATA;
                    tx_next      = rd_data_reg[0];
                    shift_next   = {1'b0, rd_data_reg[DATA_bits-1:1]};
                    bit_cnt_next = '0;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_cnt_reg == 3'(DATA_bits - 1)) begin
                        bit_cnt_next = '0;
                        if (PARITY != 0) begin
                            state_next = S_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = S_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = {1'b0, shift_reg[DATA_bits-1:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    state_next   = S_STOP;
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_cnt_reg == 3'(STOP_bits - 1)) begin
                        bit_cnt_next = '0;
                        // Chain straight into the next frame when one is queued.
                        if (!empty) begin
                            pop        = 1'b1;
                            state_next = S_START;
                            tx_next    = 1'b0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Registered busy tracks the state/count that will exist after this edge.
        busy_next = (state_next != S_IDLE) || (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_reg   <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    assign tx   = tx_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three transmitter configurations run side by side under random traffic:
//     cfg0: 8 data bits, odd parity,  1 stop, 4-deep FIFO
//     cfg1: 7 data bits, even parity, 2 stop, 4-deep FIFO
//     cfg2: 8 data bits, no parity,   1 stop, 8-deep FIFO
//   Each has a reference model made of a word queue (the FIFO contents) and a
//   queue of expected line levels for the frame in flight, one entry per
//   clock. tx, busy, ready_o and fifo_count are compared every cycle.
//   Traffic phases cycle through sparse, heavy, continuous and silent, and
//   two resets are asserted while frames are in flight.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int SYS_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DIV      = SYS_FREQ / BAUD;
    localparam int N_CYC    = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_p;
    bit   checking;
    int   cyc_cnt  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   rst_a;
    int   rst_b;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc_cnt);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
            localparam int DB  = (gi == 1) ? 7 : 8;
            localparam int PAR = (gi == 0) ? 1 : ((gi == 1) ? 2 : 0);
            localparam int SB  = (gi == 1) ? 2 : 1;
            localparam int DEP = (gi == 2) ? 8 : 4;

            logic [DB-1:0]         data_i;
            logic                  valid_i;
            logic                  ready_o;
            logic                  tx;
            logic                  busy;
            logic [$clog2(DEP):0]  fifo_count;

            uart_tx_fifo #(
                .sys_freq   (SYS_FREQ),
                .BAUD_rate  (BAUD),
                .DATA_bits  (DB),
                .PARITY     (PAR),
                .STOP_bits  (SB),
                .FIFO_depth (DEP)
            ) dut (
                .clk        (clk),
                .reset_p    (reset_p),
                .data_i     (data_i),
                .valid_i    (valid_i),
                .ready_o    (ready_o),
                .tx         (tx),
                .busy       (busy),
                .fifo_count (fifo_count)
            );

            // Reference model state
            int  q[$];      // words waiting in the FIFO
            int  line[$];   // expected tx level for each remaining cycle of the current frame
            int  w;
            int  ones;
            int  pb;
            int  ph;
            bit  accept;

            initial begin
                valid_i = 1'b0;
                data_i  = '0;
            end

            always @(posedge clk) begin
                if (reset_p) begin
                    q.delete();
                    line.delete();
                end else begin
                    accept = valid_i && (q.size() < DEP);
                    if (line.size() > 0) void'(line.pop_front());
                    // A queued word starts as soon as the line is free.
                    if (line.size() == 0 && q.size() > 0) begin
                        w = q.pop_front();
                        for (int k = 0; k < DIV; k++) line.push_back(0);
                        for (int b = 0; b < DB; b++)
                            for (int k = 0; k < DIV; k++) line.push_back((w >> b) & 1);
                        if (PAR != 0) begin
                            ones = $countones(w);
                            pb   = (PAR == 2) ? (ones % 2) : (1 - (ones % 2));
                            for (int k = 0; k < DIV; k++) line.push_back(pb);
                        end
                        for (int k = 0; k < SB * DIV; k++) line.push_back(1);
                        $display("cfg%0d cycle %0d: frame data=0x%0h, %0d cycles, %0d still queued",
                                 gi, cyc_cnt, w, line.size(), q.size());
                    end
                    if (accept) q.push_back(int'(data_i));
                end
            end

            always @(negedge clk) begin
                if (checking) begin
                    check_val($sformatf("cfg%0d_tx", gi), 32'(tx),
                              (line.size() > 0) ? 32'(line[0]) : 32'd1);
                    check_val($sformatf("cfg%0d_busy", gi), 32'(busy),
                              32'((line.size() != 0) || (q.size() != 0)));
                    check_val($sformatf("cfg%0d_ready", gi), 32'(ready_o),
                              32'(q.size() < DEP));
                    check_val($sformatf("cfg%0d_count", gi), 32'(fifo_count),
                              32'(q.size()));
                end
                ph = (cyc_cnt / 1000) % 4;
                case (ph)
                    0:       valid_i = ($urandom_range(0, 149) == 0);
                    1:       valid_i = ($urandom_range(0, 1) == 1);
                    2:       valid_i = 1'b1;
                    default: valid_i = 1'b0;
                endcase
                data_i = DB'($urandom_range(0, (1 << DB) - 1));
            end
        end
    endgenerate

    initial begin
        reset_p  = 1'b1;
        checking = 1'b0;
        rst_a    = 2300 + int'($urandom_range(0, 400));
        rst_b    = 5500 + int'($urandom_range(0, 400));
        repeat (3) @(negedge clk);
        reset_p  = 1'b0;
        checking = 1'b1;
        while (cyc_cnt < N_CYC) begin
            @(negedge clk);
            reset_p = (cyc_cnt == rst_a) || (cyc_cnt == rst_b);
            if (reset_p) $display("cycle %0d: reset asserted with traffic in flight", cyc_cnt);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
